// File: rtl/mul_result_stage_if.sv
// Valid/ready bundle between the multiplier, this result stage and the register-file writeback port.
interface mul_result_stage_if #(
  parameter int N  = 16,
  parameter int AW = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [2*N-1:0]  in_prod;
  logic [AW-1:0]   in_rd;
  logic [1:0]      in_op;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_data;
  logic [AW-1:0]   out_rd;

  modport master (
    output in_valid, in_prod, in_rd, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_rd
  );

  modport slave (
    input  in_valid, in_prod, in_rd, in_op, out_ready,
    output in_ready, out_valid, out_data, out_rd
  );
endinterface

// File: rtl/mul_result_stage.sv
// Registered result stage after the 16x16 multiplier: selects LO/HI/MAC result, buffers it in a
// small FIFO for register-file writeback, and owns the multiply-accumulate register.
module mul_result_stage #(
  parameter int N     = 16,
  parameter int AW    = 3,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mul_result_stage_if.slave  bus,
  input  logic               flush,
  output logic [2*N-1:0]     acc,
  output logic               acc_ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    OP_LO     = 2'b00,
    OP_HI     = 2'b01,
    OP_MAC    = 2'b10,
    OP_CLRACC = 2'b11
  } op_e;

  op_e             op;
  logic            live;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [N-1:0]    data_mem [DEPTH];
  logic [AW-1:0]   rd_mem   [DEPTH];
  logic            accept;
  logic            enq;
  logic            pop;
  logic [2*N:0]    acc_next;
  logic [N-1:0]    enq_data;

  assign op       = op_e'(bus.in_op);
  assign acc_next = {1'b0, acc} + {1'b0, bus.in_prod};

  // live holds in_ready low while in reset and for the first edge after release
  assign bus.in_ready  = live && (count < CW'(DEPTH)) && !flush;
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = data_mem[rd_ptr];
  assign bus.out_rd    = rd_mem[rd_ptr];

  assign accept = bus.in_valid && bus.in_ready;
  assign enq    = accept && (op != OP_CLRACC);
  assign pop    = bus.out_valid && bus.out_ready && !flush;

  always_comb begin
    enq_data = bus.in_prod[N-1:0];
    case (op)
      OP_HI:   enq_data = bus.in_prod[2*N-1:N];
      OP_MAC:  enq_data = acc_next[N-1:0];
      default: enq_data = bus.in_prod[N-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        rd_mem[i]   <= '0;
      end
    end else begin
      live <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) begin
          data_mem[wr_ptr] <= enq_data;
          rd_mem[wr_ptr]   <= bus.in_rd;
          wr_ptr           <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({enq, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Accumulator only moves on an accepted MAC/CLRACC; flush never reaches it because accept is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (accept) begin
      if (op == OP_MAC) begin
        acc <= acc_next[2*N-1:0];
        if (acc_next[2*N]) begin
          acc_ovf <= 1'b1;
        end
      end else if (op == OP_CLRACC) begin
        acc     <= '0;
        acc_ovf <= 1'b0;
      end
    end
  end

endmodule
